// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier.
// Combinational definitions only; no latency or backpressure of its own.
// Holds the three-state controller encoding used by the multiplier top.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/ripple_carry_adder10.sv
// n-bit ripple-carry adder: {cout,sum} = a + b + cin.
// Purely combinational, zero cycles of latency.
// No handshake; the caller owns all flow control.
module ripple_carry_adder10 #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[n];

endmodule

// File: rtl/shift_add_multiplier10.sv
// Unsigned sequential n x n -> 2n radix-2 shift-and-add multiplier.
// Result valid n edges after the input transfer; no overlap between operations.
// in_ready only in IDLE; product held in DONE until out_ready accepts it.
module shift_add_multiplier10
    import mult_pkg::*;
#(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*n-1:0] product,
    output logic           busy
);

    localparam int CNT_W = $clog2(n + 1);

    mult_state_t      state_q;
    mult_state_t      state_d;
    logic [n-1:0]     mcand;
    logic [n-1:0]     hi;
    logic [n-1:0]     lo;
    logic [CNT_W-1:0] cnt;
    logic [n-1:0]     sum;
    logic             cout;
    logic             last_iter;

    // The multiplier LSB gates the multiplicand into the adder each iteration.
    ripple_carry_adder10 #(.n(n)) u_add (
        .a    (hi),
        .b    (mcand & {n{lo[0]}}),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign last_iter = (cnt == CNT_W'(n - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    // Carry-out becomes the shift-in MSB, so the running sum never overflows.
                    {hi, lo} <= {cout, sum, lo[n-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = {hi, lo};

endmodule

// File: tb/tb_shift_add_multiplier10.sv
// Directed plus randomized bench for shift_add_multiplier10 at n=8, with an n=32 smoke instance.
module tb_shift_add_multiplier10;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready, busy;
    logic [N-1:0]   a, b;
    logic [2*N-1:0] product;

    logic          in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [31:0]   a32, b32;
    logic [63:0]   product32;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier10 #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    shift_add_multiplier10 #(.n(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .a         (a32),
        .b         (b32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .product   (product32),
        .busy      (busy32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges until out_valid, giving up after a fixed budget.
    task automatic wait_out(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    // One complete operation with out_ready=1: latency, product, and return to IDLE.
    task automatic run_one(input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
        int lat;
        longint exp;
        exp = longint'(x) * longint'(y);
        a = x;
        b = y;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_out(lat);
        check({tag, "_latency"}, lat, N);
        check({tag, "_product"}, product, exp);
        tick();
        check({tag, "_out_valid_drop"}, out_valid, 0);
        check({tag, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        int edges;
        logic [N-1:0] x, y;
        longint exp;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);

        // Reset coinciding with a handshake must win
        in_valid = 1'b1; a = 8'd5; b = 8'd5;
        tick();
        check("rst_vs_hs_in_ready", in_ready, 1);
        check("rst_vs_hs_busy", busy, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();

        // Directed cases
        run_one(8'd13, 8'd11, "basic");
        run_one(8'd255, 8'd255, "max");
        run_one(8'd0, 8'd200, "a_zero");
        run_one(8'd77, 8'd0, "b_zero");

        // Backpressure in DONE
        out_ready = 1'b0;
        a = 8'd200; b = 8'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("bp_latency", lat, N);
        for (int i = 0; i < 5; i++) begin
            check("bp_product_stable", product, 16'd600);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_product_final", product, 16'd600);
        tick();
        check("bp_released", out_valid, 0);
        check("bp_idle", in_ready, 1);

        // Mid-operation reset at iteration 4
        a = 8'd200; b = 8'd100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_product", product, 0);
        run_one(8'd3, 8'd5, "after_rst");

        // Back-to-back with in_valid held high; operands change while busy
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("b2b_in_ready", in_ready, 1);
            x = N'($urandom_range(0, 255));
            y = N'($urandom_range(0, 255));
            exp = longint'(x) * longint'(y);
            a = x;
            b = y;
            tick();
            a = N'($urandom);
            b = N'($urandom);
            edges = 0;
            while (out_valid !== 1'b1 && edges < 200) begin
                check("b2b_calc_not_ready", in_ready, 0);
                tick();
                edges++;
            end
            check("b2b_latency", edges, N);
            check("b2b_product", product, exp);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // n=32 smoke test
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        edges = 0;
        while (out_valid32 !== 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
        check("n32_latency", edges, 32);
        check("n32_product", product32, 64'hFFFF_FFFE_0000_0001);
        tick();
        check("n32_idle", in_ready32, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
